// File: rtl/uart_echo_top_if.sv
// Serial pin bundle for the bring-up UART.
// master = board/pin side, slave = uart_echo_top.
interface uart_echo_top_if;
   logic start;
   logic sout;
   logic txrdy_n;
   logic sin;
   logic rxrdy_n;

   modport master (
      output start,
      output sin,
      input  sout,
      input  txrdy_n,
      input  rxrdy_n
   );

   modport slave (
      input  start,
      input  sin,
      output sout,
      output txrdy_n,
      output rxrdy_n
   );
endinterface

// File: rtl/uart_echo_top.sv
// 8N1 UART: banner transmit on start, echo of received bytes.
// One clock domain; rx buffer is the only tx/rx coupling.
module uart_echo_top #(
   parameter int CLK_HZ = 38000000,
   parameter int BAUD   = 115200
) (
   input  logic      clk,
   input  logic      resetn,
   uart_echo_top_if.slave bus
);

   localparam int DIVISOR = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int HALF    = DIVISOR / 2;
   localparam int CW      = $clog2(DIVISOR);

   localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   function automatic logic [7:0] rom(input logic [2:0] i);
      logic [7:0] b;
      unique case (i)
         3'd0: b = 8'h44;
         3'd1: b = 8'h72;
         3'd2: b = 8'h6F;
         3'd3: b = 8'h6E;
         3'd4: b = 8'h65;
         3'd5: b = 8'h32;
         3'd6: b = 8'h0D;
         3'd7: b = 8'h0A;
      endcase
      return b;
   endfunction

   // ---------------- TX ----------------
   state_t        tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [2:0]    tx_byte, tx_byte_n;
   logic [7:0]    tx_sh, tx_sh_n;
   logic          tx_ban, tx_ban_n;
   logic          sout_q, sout_n;
   logic          busy_q, busy_n;
   logic          tx_take;

   // ---------------- RX ----------------
   logic          s1, s2, s3;
   state_t        rx_state, rx_state_n;
   logic [CW-1:0] rx_cnt, rx_cnt_n;
   logic [2:0]    rx_bit, rx_bit_n;
   logic [7:0]    rx_sh, rx_sh_n;
   logic          rx_wr;
   logic [7:0]    rx_buf;
   logic          rx_full;

   // TX next state: idle arbitration (echo first), then bit sequencing
   always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_byte_n  = tx_byte;
      tx_sh_n    = tx_sh;
      tx_ban_n   = tx_ban;
      sout_n     = sout_q;
      busy_n     = busy_q;
      tx_take    = 1'b0;
      unique case (tx_state)
         IDLE: begin
            if (rx_full) begin
               tx_take    = 1'b1;
               tx_sh_n    = rx_buf;
               tx_ban_n   = 1'b0;
               tx_state_n = START;
               tx_cnt_n   = '0;
               sout_n     = 1'b0;
               busy_n     = 1'b1;
            end else if (bus.start) begin
               tx_sh_n    = rom(3'd0);
               tx_byte_n  = 3'd0;
               tx_ban_n   = 1'b1;
               tx_state_n = START;
               tx_cnt_n   = '0;
               sout_n     = 1'b0;
               busy_n     = 1'b1;
            end
         end
         START: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n   = '0;
               tx_bit_n   = 3'd0;
               tx_state_n = DATA;
               sout_n     = tx_sh[0];
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         DATA: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               if (tx_bit == 3'd7) begin
                  tx_state_n = STOP;
                  sout_n     = 1'b1;
               end else begin
                  tx_bit_n = tx_bit + 1'b1;
                  tx_sh_n  = {1'b0, tx_sh[7:1]};
                  sout_n   = tx_sh[1];
               end
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
         STOP: begin
            if (tx_cnt == BIT_LAST) begin
               tx_cnt_n = '0;
               // banner frames chain with no idle bit between them
               if (tx_ban && tx_byte != 3'd7) begin
                  tx_byte_n  = tx_byte + 1'b1;
                  tx_sh_n    = rom(tx_byte + 1'b1);
                  tx_state_n = START;
                  sout_n     = 1'b0;
               end else begin
                  tx_state_n = IDLE;
                  tx_ban_n   = 1'b0;
                  busy_n     = 1'b0;
               end
            end else begin
               tx_cnt_n = tx_cnt + 1'b1;
            end
         end
      endcase
   end

   // TX state register
   always_ff @(posedge clk) begin
      if (resetn) begin
         tx_state <= IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_byte  <= '0;
         tx_sh    <= '0;
         tx_ban   <= 1'b0;
         sout_q   <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         tx_state <= tx_state_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_byte  <= tx_byte_n;
         tx_sh    <= tx_sh_n;
         tx_ban   <= tx_ban_n;
         sout_q   <= sout_n;
         busy_q   <= busy_n;
      end
   end

   // sin synchronizer plus one history flop for edge detect
   always_ff @(posedge clk) begin
      if (resetn) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= bus.sin;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // RX next state: start qualify at half bit, then mid-bit sampling
   always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_bit_n   = rx_bit;
      rx_sh_n    = rx_sh;
      rx_wr      = 1'b0;
      unique case (rx_state)
         IDLE: begin
            if (s3 && !s2) begin
               rx_state_n = START;
               rx_cnt_n   = '0;
            end
         end
         START: begin
            if (rx_cnt == HALF_LAST) begin
               rx_cnt_n   = '0;
               rx_bit_n   = 3'd0;
               rx_state_n = s2 ? IDLE : DATA;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         DATA: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n = '0;
               rx_sh_n  = {s2, rx_sh[7:1]};
               if (rx_bit == 3'd7) begin
                  rx_state_n = STOP;
               end else begin
                  rx_bit_n = rx_bit + 1'b1;
               end
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
         STOP: begin
            if (rx_cnt == BIT_LAST) begin
               rx_cnt_n   = '0;
               rx_state_n = IDLE;
               rx_wr      = s2;
            end else begin
               rx_cnt_n = rx_cnt + 1'b1;
            end
         end
      endcase
   end

   // RX state register
   always_ff @(posedge clk) begin
      if (resetn) begin
         rx_state <= IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_sh    <= '0;
      end else begin
         rx_state <= rx_state_n;
         rx_cnt   <= rx_cnt_n;
         rx_bit   <= rx_bit_n;
         rx_sh    <= rx_sh_n;
      end
   end

   // rx buffer: a fresh byte beats a same-clock echo take
   always_ff @(posedge clk) begin
      if (resetn) begin
         rx_buf  <= '0;
         rx_full <= 1'b0;
      end else if (rx_wr) begin
         rx_buf  <= rx_sh;
         rx_full <= 1'b1;
      end else if (tx_take) begin
         rx_full <= 1'b0;
      end
   end

   assign bus.sout    = sout_q;
   assign bus.txrdy_n = busy_q;
   assign bus.rxrdy_n = ~rx_full;

endmodule

// File: tb/tb_uart_echo_top.sv
// Directed bench for uart_echo_top: banner, repeat, echo,
// line errors and mid-frame reset, at 330 clocks per bit.
module tb_uart_echo_top;

   localparam int DIV = 330;

   logic clk = 1'b0;
   logic resetn;
   int   n_vec = 0;
   int   n_err = 0;
   int   hi_cyc;
   int   stop_bad;
   int   rx_lo;
   int   tx_hi;
   int   sout_lo;
   bit   ok;
   logic [7:0] banner [8];
   logic [7:0] cap [8];

   always #5 clk = ~clk;

   uart_echo_top_if bus();

   uart_echo_top #(
      .CLK_HZ(38000000),
      .BAUD  (115200)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (bus.rxrdy_n === 1'b0) rx_lo++;
         if (bus.txrdy_n === 1'b1) tx_hi++;
         if (bus.sout !== 1'b1) sout_lo++;
      end
   endtask

   task automatic wait_rise(input int budget, output bit found);
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.txrdy_n === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
   endtask

   // current sample is the first clock of the first start bit
   task automatic capture(input int nb);
      int cyc;
      int p;
      int b;
      int k;
      cyc = 0;
      stop_bad = 0;
      for (int i = 0; i < 8; i++) cap[i] = 8'h00;
      while (bus.txrdy_n === 1'b1 && cyc < 30000) begin
         if (cyc % DIV == DIV / 2) begin
            p = cyc / DIV;
            b = p / 10;
            k = p % 10;
            if (b < nb) begin
               if (k == 0 && bus.sout !== 1'b0) stop_bad++;
               else if (k == 9 && bus.sout !== 1'b1) stop_bad++;
               else if (k >= 1 && k <= 8) cap[b][k-1] = bus.sout;
            end
         end
         cyc++;
         tick();
      end
      hi_cyc = cyc;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stopv);
      logic [9:0] fr;
      fr = {stopv, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         bus.sin = fr[i];
         watch(DIV);
      end
      bus.sin = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      banner[0] = 8'h44; banner[1] = 8'h72;
      banner[2] = 8'h6F; banner[3] = 8'h6E;
      banner[4] = 8'h65; banner[5] = 8'h32;
      banner[6] = 8'h0D; banner[7] = 8'h0A;
      resetn = 1'b1;
      bus.start = 1'b0;
      bus.sin = 1'b1;
      tick();
      resetn = 1'b0;
      check("rst_sout", bus.sout, 1);
      check("rst_txrdy_n", bus.txrdy_n, 0);
      check("rst_rxrdy_n", bus.rxrdy_n, 1);

      // banner, start dropped once accepted
      bus.start = 1'b1;
      tick();
      wait_rise(10, ok);
      check("ban_rise", ok, 1);
      check("ban_first_sb", bus.sout, 0);
      bus.start = 1'b0;
      capture(8);
      check("ban_len", hi_cyc, 26400);
      check("ban_framing", stop_bad, 0);
      for (int i = 0; i < 8; i++) check("ban_byte", cap[i], banner[i]);
      tx_hi = 0; sout_lo = 0; rx_lo = 0;
      watch(400);
      check("ban_no_repeat", tx_hi, 0);
      check("ban_idle_sout", sout_lo, 0);

      // start held: banner repeats one clock after txrdy_n falls
      bus.start = 1'b1;
      tick();
      wait_rise(10, ok);
      check("rep_rise", ok, 1);
      capture(8);
      check("rep_len", hi_cyc, 26400);
      check("rep_byte0", cap[0], 8'h44);
      check("rep_byte7", cap[7], 8'h0A);
      check("rep_fall", bus.txrdy_n, 0);
      tick();
      check("rep_restart", bus.txrdy_n, 1);
      check("rep_restart_sb", bus.sout, 0);
      bus.start = 1'b0;

      // reset mid byte 3 (data bit 4 of 0x6E is 0)
      repeat (35 * DIV) tick();
      check("pre_rst_sout", bus.sout, 0);
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      check("mid_rst_sout", bus.sout, 1);
      check("mid_rst_txrdy_n", bus.txrdy_n, 0);
      tx_hi = 0; sout_lo = 0;
      watch(500);
      check("post_rst_quiet_tx", tx_hi, 0);
      check("post_rst_quiet_sout", sout_lo, 0);

      // echo of 0xA5
      fork
         send_byte(8'hA5, 1'b1);
         begin
            ok = 1'b0;
            for (int i = 0; i < 4000; i++) begin
               tick();
               if (bus.rxrdy_n === 1'b0) begin
                  ok = 1'b1;
                  break;
               end
            end
            check("echo_rxrdy_low", ok, 1);
            tick();
            check("echo_rxrdy_clr", bus.rxrdy_n, 1);
            check("echo_txrdy", bus.txrdy_n, 1);
            check("echo_sb", bus.sout, 0);
            capture(1);
            check("echo_len", hi_cyc, 3300);
            check("echo_byte", cap[0], 8'hA5);
            check("echo_framing", stop_bad, 0);
         end
      join
      watch(50);

      // false start: 100-clock low glitch
      rx_lo = 0; tx_hi = 0;
      bus.sin = 1'b0;
      watch(100);
      bus.sin = 1'b1;
      watch(1000);
      check("glitch_rxrdy", rx_lo, 0);
      check("glitch_tx", tx_hi, 0);

      // framing error: 0x3C with stop bit 0
      rx_lo = 0; tx_hi = 0;
      send_byte(8'h3C, 1'b0);
      watch(1000);
      check("frm_rxrdy", rx_lo, 0);
      check("frm_no_echo", tx_hi, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_echo_top.md
Name: uart_echo_top

Overview:
- Self-contained 8N1 UART block for board bring-up on the Drone2 SOC, clocked from the on-chip oscillator (nominal 38 MHz).
- A `start` request transmits a fixed ASCII banner on `sout`.
- Bytes received on `sin` are buffered, flagged on `rxrdy_n`, and echoed back out of `sout`.
- Sits at top level between the oscillator and the debug serial pins.

Parameters:
- CLK_HZ, 38000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIVISOR (localparam), round(CLK_HZ/BAUD) = 330, clocks per bit.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- resetn  input  1  synchronous, active-high reset. Name kept for codebase consistency; asserted = 1.
- start  input  1  banner transmit request; level-sampled.
- sout  output  1  serial TX line; idles high.
- txrdy_n  output  1  0 = transmitter idle, 1 = transmitter busy.
- sin  input  1  serial RX line; asynchronous, idles high.
- rxrdy_n  output  1  0 = received byte waiting in buffer, 1 = buffer empty.

Behaviour:
- One clock domain. Reset is sampled on the clk rising edge while resetn=1. Reset mid-operation aborts any frame.
- Reset values: sout=1, txrdy_n=0, rxrdy_n=1, RX buffer empty. Both FSMs go to IDLE and all counters clear.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity. Each bit lasts exactly DIVISOR clocks.
- Banner ROM, 8 bytes, in order: 0x44 0x72 0x6F 0x6E 0x65 0x32 0x0D 0x0A ("Drone2\r\n").
- TX FSM states: IDLE, START, DATA, STOP.
  - In IDLE, the FSM arbitrates once per clock, with priority in this order:
    - (1) RX buffer full: load the buffer byte as an echo, set rxrdy_n=1 in the same clock, and send 1 byte.
    - (2) start=1: send all 8 banner bytes back-to-back, with no idle bit between frames.
  - txrdy_n goes to 1 in the clock after the request is accepted. It stays 1 until the last stop bit completes, then returns to 0.
  - The first start bit drives sout=0 in the same clock that txrdy_n rises.
  - start is ignored while busy. If start is still 1 when the TX returns to IDLE, the banner repeats.
- RX path:
  - sin passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - A falling edge in IDLE enters START. The line is rechecked after DIVISOR/2 clocks; if it is high, this is a false start and the FSM returns to IDLE.
  - Data bits are sampled every DIVISOR clocks at mid-bit.
  - Stop sample = 1: byte written to buffer, rxrdy_n=0 in the next clock.
  - Stop sample = 0 (framing error): byte discarded, rxrdy_n unchanged.
  - Overrun (new valid byte while buffer full): the buffer is overwritten and rxrdy_n stays 0.
  - If a new byte is written in the same clock the TX takes the buffer for echo, the new byte wins and rxrdy_n stays 0.
- Timing:
  - Full banner = 80 bit times = 26400 clocks (~0.695 ms at 38 MHz).
  - Echo byte = 3300 clocks.
- RX and TX run concurrently and independently, except for the buffer hand-off described above.

Test Plan:
- Reset then pulse: resetn=1 for one clock, then 0. Expect sout=1, txrdy_n=0, rxrdy_n=1.
- Banner with start held: assert start until txrdy_n rises, then drop it. Expect:
  - txrdy_n=1 for exactly 26400 clocks.
  - sout decodes (bit-sampled every 330 clocks) to 44 72 6F 6E 65 32 0D 0A.
  - txrdy_n returns to 0 afterwards and stays 0 with no repeat.
- Banner repeat: hold start=1 continuously. Expect a second banner to begin one clock after txrdy_n falls.
- Echo: drive byte 0xA5 on sin at 330 clocks/bit with start=0. Expect:
  - rxrdy_n=0 after the stop sample, then back to 1 as the echo loads.
  - sout carries frame 0xA5 and txrdy_n is high for 3300 clocks.
- Errors on sin:
  - A 100-clock low glitch (false start) leaves rxrdy_n=1.
  - Byte 0x3C sent with stop bit = 0 (framing error) leaves rxrdy_n=1 and produces no echo.
- Reset mid-frame: assert resetn midway through banner byte 3. Expect sout=1 and txrdy_n=0 in the next clock, and no further output until a new start.
